vga_timing_gen: RTL and testbench

//   Parametrised VGA raster timing generator; successor to the fixed 640x480 controller.

---
 rtl/vga_timing_gen.sv | 126 ++++++++++++
 tb/tb_vga_timing_gen.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Parametrised VGA raster timing generator. A clock divider produces a pixel
//   tick; horizontal/vertical counters walk the raster, and every output
//   (sync, video_on, coordinates, strobes) is registered and computed from the
//   counters' next values so that all of them change on the same edge.
//
// Ports
//   i_clk          board clock
//   i_rst_n        asynchronous active-low reset
//   i_en           timing enable; low freezes the raster
//   o_p_tick       pixel tick, one clk wide (continuous when CLK_DIV=1)
//   o_hsync        horizontal sync, active level HSYNC_POL
//   o_vsync        vertical sync, active level VSYNC_POL
//   o_video_on     (x,y) inside the visible area
//   o_x / o_y      current pixel column / line
//   o_line_start   one-clk strobe, x just became 0
//   o_frame_start  one-clk strobe, (x,y) just became (0,0)
module vga_timing_gen #(
  parameter int CLK_DIV   = 4,
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int HSYNC_POL = 0,
  parameter int VSYNC_POL = 0,
  parameter int CNT_W     = 10
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  output logic             o_p_tick,
  output logic             o_hsync,
  output logic             o_vsync,
  output logic             o_video_on,
  output logic [CNT_W-1:0] o_x,
  output logic [CNT_W-1:0] o_y,
  output logic             o_line_start,
  output logic             o_frame_start
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_DISPLAY);
  localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_DISPLAY);
  localparam logic [CNT_W-1:0] HS_BEG   = CNT_W'(H_DISPLAY + H_FRONT);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_BEG   = CNT_W'(V_DISPLAY + V_FRONT);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_DISPLAY + V_FRONT + V_SYNC - 1);
  localparam logic             HS_ACT   = 1'(HSYNC_POL);
  localparam logic             VS_ACT   = 1'(VSYNC_POL);

  logic [DIV_W-1:0] r_div;
  logic             r_tick;
  logic             r_hs, r_vs, r_vid, r_ls, r_fs;
  logic [CNT_W-1:0] r_x, r_y;

  logic             w_tick;
  logic             w_x_wrap;
  logic [CNT_W-1:0] w_x_nxt, w_y_nxt;
  logic             w_hs_nxt, w_vs_nxt, w_vid_nxt;

  // The tick is generated combinationally from the divider and registered
  // together with the counters, so p_tick rises on the same edge that moves x.
  always_comb begin
    w_tick    = i_en && (r_div == DIV_LAST);
    w_x_wrap  = (r_x == H_LAST);
    w_x_nxt   = w_x_wrap ? '0 : r_x + CNT_W'(1);
    w_y_nxt   = r_y;
    if (w_x_wrap) w_y_nxt = (r_y == V_LAST) ? '0 : r_y + CNT_W'(1);
    // Decode from next values: registered outputs then line up with x/y.
    w_hs_nxt  = ((w_x_nxt >= HS_BEG) && (w_x_nxt <= HS_END)) ? HS_ACT : ~HS_ACT;
    w_vs_nxt  = ((w_y_nxt >= VS_BEG) && (w_y_nxt <= VS_END)) ? VS_ACT : ~VS_ACT;
    w_vid_nxt = (w_x_nxt < H_VIS) && (w_y_nxt < V_VIS);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_div  <= '0;
      r_tick <= 1'b0;
      // Parked on the last back-porch pixel so the first tick lands on (0,0).
      r_x    <= H_LAST;
      r_y    <= V_LAST;
      r_hs   <= ~HS_ACT;
      r_vs   <= ~VS_ACT;
      r_vid  <= 1'b0;
      r_ls   <= 1'b0;
      r_fs   <= 1'b0;
    end else if (i_en) begin
      r_div  <= (r_div == DIV_LAST) ? '0 : r_div + DIV_W'(1);
      r_tick <= w_tick;
      r_ls   <= w_tick && (w_x_nxt == '0);
      r_fs   <= w_tick && (w_x_nxt == '0) && (w_y_nxt == '0);
      if (w_tick) begin
        r_x   <= w_x_nxt;
        r_y   <= w_y_nxt;
        r_hs  <= w_hs_nxt;
        r_vs  <= w_vs_nxt;
        r_vid <= w_vid_nxt;
      end
    end else begin
      // Frozen: divider and raster hold, single-cycle outputs drop.
      r_tick <= 1'b0;
      r_ls   <= 1'b0;
      r_fs   <= 1'b0;
    end
  end

  assign o_p_tick      = r_tick;
  assign o_hsync       = r_hs;
  assign o_vsync       = r_vs;
  assign o_video_on    = r_vid;
  assign o_x           = r_x;
  assign o_y           = r_y;
  assign o_line_start  = r_ls;
  assign o_frame_start = r_fs;

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // d: default 640x480 timing
  logic       d_rn, d_en, d_tick, d_hs, d_vs, d_vid, d_ls, d_fs;
  logic [9:0] d_x, d_y;
  vga_timing_gen u_d (
    .i_clk(clk), .i_rst_n(d_rn), .i_en(d_en), .o_p_tick(d_tick),
    .o_hsync(d_hs), .o_vsync(d_vs), .o_video_on(d_vid), .o_x(d_x), .o_y(d_y),
    .o_line_start(d_ls), .o_frame_start(d_fs));

  // s: small raster, CLK_DIV=2, H 16/2/3/2 (23), V 12/2/2/2 (18), active-low syncs
  logic       s_rn, s_en, s_tick, s_hs, s_vs, s_vid, s_ls, s_fs;
  logic [4:0] s_x, s_y;
  vga_timing_gen #(.CLK_DIV(2), .H_DISPLAY(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
                   .V_DISPLAY(12), .V_FRONT(2), .V_SYNC(2), .V_BACK(2), .CNT_W(5)) u_s (
    .i_clk(clk), .i_rst_n(s_rn), .i_en(s_en), .o_p_tick(s_tick),
    .o_hsync(s_hs), .o_vsync(s_vs), .o_video_on(s_vid), .o_x(s_x), .o_y(s_y),
    .o_line_start(s_ls), .o_frame_start(s_fs));

  // t: tiny raster, CLK_DIV=1, H 4/1/2/1 (8), V 3/1/1/1 (6), active-high syncs
  logic       t_rn, t_en, t_tick, t_hs, t_vs, t_vid, t_ls, t_fs;
  logic [3:0] t_x, t_y;
  vga_timing_gen #(.CLK_DIV(1), .H_DISPLAY(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
                   .V_DISPLAY(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
                   .HSYNC_POL(1), .VSYNC_POL(1), .CNT_W(4)) u_t (
    .i_clk(clk), .i_rst_n(t_rn), .i_en(t_en), .o_p_tick(t_tick),
    .o_hsync(t_hs), .o_vsync(t_vs), .o_video_on(t_vid), .o_x(t_x), .o_y(t_y),
    .o_line_start(t_ls), .o_frame_start(t_fs));

  int n;
  int ex, ey;

  initial begin
    d_rn = 1'b0; s_rn = 1'b0; t_rn = 1'b0;
    d_en = 1'b1; s_en = 1'b1; t_en = 1'b1;
    repeat (3) @(negedge clk);

    // ---- default: reset state and first ticks
    chk("d_rst_x", d_x, 799);     chk("d_rst_y", d_y, 524);
    chk("d_rst_tick", d_tick, 0); chk("d_rst_vid", d_vid, 0);
    chk("d_rst_hs", d_hs, 1);     chk("d_rst_vs", d_vs, 1);
    chk("d_rst_ls", d_ls, 0);     chk("d_rst_fs", d_fs, 0);
    d_rn = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      chk("d_tick_seq", d_tick, (c % 4 == 0));
      if (c == 3) chk("d_x_pre", d_x, 799);
      if (c == 4) begin
        chk("d_first_x", d_x, 0);   chk("d_first_y", d_y, 0);
        chk("d_first_vid", d_vid, 1);
        chk("d_first_fs", d_fs, 1); chk("d_first_ls", d_ls, 1);
        chk("d_first_hs", d_hs, 1); chk("d_first_vs", d_vs, 1);
      end
      if (c == 5) begin
        chk("d_fs_drop", d_fs, 0); chk("d_ls_drop", d_ls, 0); chk("d_x_hold", d_x, 0);
      end
    end
    chk("d_x_second", d_x, 1);

    // ---- default: freeze at x=100 with the divider holding 2
    n = 0;
    while (d_x != 100 && n < 2000) begin @(negedge clk); n++; end
    chk("d_reach100", d_x, 100);
    repeat (2) @(negedge clk);
    d_en = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("d_hold_tick", d_tick, 0);
      chk("d_hold_x", d_x, 100);
      chk("d_hold_vid", d_vid, 1);
    end
    d_en = 1'b1;
    @(negedge clk); chk("d_res1_x", d_x, 100); chk("d_res1_tick", d_tick, 0);
    @(negedge clk); chk("d_res2_x", d_x, 101); chk("d_res2_tick", d_tick, 1);

    // ---- default: rest of line 0, hsync window 656..751 and video window
    n = 0;
    while (!(d_x == 0 && d_y == 1) && n < 4000) begin
      @(negedge clk); n++;
      chk("d_hs_dec", d_hs, !(d_x >= 656 && d_x <= 751));
      chk("d_vid_dec", d_vid, (d_x < 640));
      chk("d_vs_line0", d_vs, 1);
    end
    chk("d_line1_y", d_y, 1);
    chk("d_line1_ls", d_ls, 1);
    chk("d_line1_fs", d_fs, 0);
    d_rn = 1'b0;

    // ---- small: run to (10,7), then async reset mid-frame
    s_rn = 1'b1;
    n = 0;
    while (!(s_x == 10 && s_y == 7) && n < 1000) begin @(negedge clk); n++; end
    chk("s_reach", (s_x == 10 && s_y == 7), 1);
    chk("s_mid_vid", s_vid, 1);
    @(posedge clk); #2 s_rn = 1'b0;
    #1;
    chk("s_arst_x", s_x, 22);     chk("s_arst_y", s_y, 17);
    chk("s_arst_tick", s_tick, 0); chk("s_arst_vid", s_vid, 0);
    chk("s_arst_hs", s_hs, 1);    chk("s_arst_vs", s_vs, 1);
    @(negedge clk);
    s_rn = 1'b1;
    @(negedge clk); chk("s_rel1_tick", s_tick, 0); chk("s_rel1_x", s_x, 22);
    @(negedge clk);
    chk("s_rel2_tick", s_tick, 1); chk("s_rel2_x", s_x, 0); chk("s_rel2_y", s_y, 0);
    chk("s_rel2_fs", s_fs, 1);     chk("s_rel2_ls", s_ls, 1);

    // ---- small: one full frame (23*18*2 = 828 clks), every edge checked
    for (int k = 1; k <= 828; k++) begin
      @(negedge clk);
      ex = (k / 2) % 23;
      ey = (k / 2 / 23) % 18;
      chk("s_tick", s_tick, (k % 2 == 0));
      chk("s_x", s_x, ex);
      chk("s_y", s_y, ey);
      chk("s_hs", s_hs, !(ex >= 18 && ex <= 20));
      chk("s_vs", s_vs, !(ey >= 14 && ey <= 15));
      chk("s_vid", s_vid, (ex < 16 && ey < 12));
      chk("s_ls", s_ls, (k % 2 == 0 && ex == 0));
      chk("s_fs", s_fs, (k == 828));
    end
    s_rn = 1'b0;

    // ---- tiny: CLK_DIV=1, active-high syncs, 48-clk frame
    chk("t_rst_x", t_x, 7);  chk("t_rst_y", t_y, 5);
    chk("t_rst_hs", t_hs, 0); chk("t_rst_vs", t_vs, 0);
    t_rn = 1'b1;
    for (int k = 0; k <= 48; k++) begin
      @(negedge clk);
      ex = k % 8;
      ey = (k / 8) % 6;
      chk("t_tick", t_tick, 1);
      chk("t_x", t_x, ex);
      chk("t_y", t_y, ey);
      chk("t_vid", t_vid, (ex < 4 && ey < 3));
      chk("t_hs", t_hs, (ex == 5 || ex == 6));
      chk("t_vs", t_vs, (ey == 4));
      chk("t_ls", t_ls, (ex == 0));
      chk("t_fs", t_fs, (k % 48 == 0));
    end
    t_en = 1'b0;
    @(negedge clk);
    chk("t_en_off_tick", t_tick, 0);
    chk("t_en_off_x", t_x, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
